// File: rtl/mips_mem_arb_pkg.sv
// Shared types and default sizes for the data-memory port arbiter.
package mips_mem_arb_pkg;

  // Port ownership: CPU owns the port by default; ST_DBG holds a locked debug burst.
  typedef enum logic {
    ST_CPU = 1'b0,
    ST_DBG = 1'b1
  } arb_state_e;

  localparam int ARB_ADDR_W     = 6;
  localparam int ARB_DATA_W     = 32;
  localparam int ARB_STARVE_MAX = 4;
  localparam int ARB_BURST_MAX  = 8;

  // Bits needed to hold the values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear.
// clr_i and inc_i together load the value 1, which starts a new count in one cycle.
module arb_sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear (optionally restart at 1), else increment until MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? W'(1) : '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port data-memory arbiter between the MEM pipeline stage and a debug port.
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN enables the debug starvation
// guard (a debug request blocked for STARVE_MAX-1 cycles is forced through).
//
// Handshake: a debug transfer happens in a cycle where dbg_valid & dbg_ready;
// the requester keeps dbg_* stable until then. The CPU sees cpu_stall instead
// and its inputs are held by the frozen pipeline. A debug read granted in cycle
// N returns dbg_rdata with a one-cycle dbg_rvalid pulse in cycle N+1.
module mem_port_arbiter
  import mips_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int STARVE_MAX = ARB_STARVE_MAX,
  parameter int BURST_MAX  = ARB_BURST_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic [DATA_W-1:0] cpu_rd,
  output logic              cpu_stall,
  input  logic              dbg_valid,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wd,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rd,
  output arb_state_e        arb_state
);

  localparam int              BW         = cnt_width(BURST_MAX);
  localparam logic [BW-1:0]   BURST_LAST = BW'(BURST_MAX - 1);
  localparam bit              BURST_EN   = (BURST_MAX > 1);

  arb_state_e        state_q, state_d;
  logic              owed_q, owed_d;     // CPU is owed one grant after a burst ends
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              grant_cpu, grant_dbg, force_dbg;
  logic              burst_clr, burst_inc;
  logic [BW-1:0]     burst_cnt;

  arb_sat_counter #(.W(BW), .MAX(BURST_MAX)) u_burst_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (burst_clr),
    .inc_i (burst_inc),
    .cnt_o (burst_cnt)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int            SW          = cnt_width(STARVE_MAX - 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

  logic [SW-1:0] starve_cnt;

  // Counts consecutive blocked debug cycles; any debug grant or idle debug clears it.
  arb_sat_counter #(.W(SW), .MAX(STARVE_MAX - 1)) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (~dbg_valid | grant_dbg),
    .inc_i (dbg_valid & ~grant_dbg),
    .cnt_o (starve_cnt)
  );

  // The owed post-burst CPU grant takes precedence over a forced debug grant.
  assign force_dbg = dbg_valid & cpu_req & ~owed_q & (starve_cnt == STARVE_LAST);
`else
  assign force_dbg = 1'b0;
`endif

  // Ownership FSM: grant selection, burst tracking and next state.
  always_comb begin
    state_d   = state_q;
    owed_d    = 1'b0;
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    burst_clr = 1'b0;
    burst_inc = 1'b0;
    case (state_q)
      ST_CPU: begin
        burst_clr = 1'b1;
        if (cpu_req && !force_dbg) grant_cpu = 1'b1;
        else if (dbg_valid)        grant_dbg = 1'b1;
        if (grant_dbg && dbg_lock && BURST_EN) begin
          state_d   = ST_DBG;
          burst_inc = 1'b1;
        end
      end
      ST_DBG: begin
        grant_dbg = dbg_valid;
        burst_inc = dbg_valid;
        // burst_cnt == BURST_MAX-1 means this grant is the BURST_MAX-th of the burst.
        if (!dbg_lock || !dbg_valid || (burst_cnt == BURST_LAST)) begin
          state_d   = ST_CPU;
          owed_d    = 1'b1;
          burst_clr = 1'b1;
          burst_inc = 1'b0;
        end
      end
      default: begin
        state_d = ST_CPU;
      end
    endcase
    // No access of any kind is issued in a reset cycle.
    if (rst) begin
      grant_cpu = 1'b0;
      grant_dbg = 1'b0;
    end
  end

  // Memory port steering and requester status.
  always_comb begin
    mem_addr  = grant_dbg ? dbg_addr : cpu_addr;
    mem_wd    = grant_dbg ? dbg_wd   : cpu_wd;
    mem_we    = (grant_cpu & cpu_we)  | (grant_dbg & dbg_we);
    mem_re    = (grant_cpu & ~cpu_we) | (grant_dbg & ~dbg_we);
    cpu_stall = cpu_req & ~grant_cpu;
    dbg_ready = grant_dbg;
    cpu_rd    = mem_rd;
    rvalid_d  = grant_dbg & ~dbg_we;
    rdata_d   = rvalid_d ? mem_rd : rdata_q;
  end

  // State and debug read-return registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_CPU;
      owed_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owed_q   <= owed_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dbg_rvalid = rvalid_q;
  assign dbg_rdata  = rdata_q;
  assign arb_state  = state_q;

endmodule
